uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per bit (50 MHz / 115200 baud); legal range 8..65535.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx_en  input  1  receiver enable, driven by the UART control register.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rd_ack  input  1  one-cycle pulse when the CPU has consumed rx_data.
REQ-007 SHALL have port rx_data  output  8  oldest received byte.
REQ-008 SHALL have port receive_flag  output  1  high while at least one byte is buffered.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port overrun  output  1  sticky: a byte was dropped because the buffer was full.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-012 SHALL implement FSM IDLE, START, DATA, STOP.
REQ-013 IDLE: synchronized rx = 0 and rx_en = 1 -> START, bit counter cleared.
REQ-014 START: at CLKS_PER_BIT/2 cycles, rx = 0 -> DATA; rx = 1 -> IDLE (false start, nothing stored).
REQ-015 DATA: sample every CLKS_PER_BIT cycles; 8 bits, LSB first, shifted into the receive register; after bit 7 -> STOP.
REQ-016 STOP: sample after CLKS_PER_BIT cycles; rx = 1 -> push byte, IDLE; rx = 0 -> frame_err high for exactly one cycle, byte discarded, IDLE.
REQ-017 The push SHALL be visible (receive_flag = 1, rx_data valid) the cycle after the stop-bit sample.
REQ-018 rx_en = 0 in any non-IDLE state SHALL abort to IDLE the next cycle; no push, no frame_err; buffered bytes are retained.
REQ-019 rd_ack with the buffer non-empty SHALL pop one byte; rd_ack with the buffer empty SHALL be ignored.
REQ-020 A push into a full buffer SHALL drop the new byte and set overrun; overrun SHALL clear on the next rd_ack.
REQ-021 A push and an rd_ack in the same cycle SHALL do both, with no overrun, even when the buffer is full.
REQ-022 rx_data SHALL hold its last value when the buffer is empty.

Reset
REQ-023 reset SHALL force the FSM to IDLE and clear the counters and buffer.
REQ-024 After reset: rx_data = 0, receive_flag = 0, frame_err = 0, overrun = 0, synchronizer flops = 1.
REQ-025 reset SHALL take priority over every other input, including mid-frame.

Configuration
REQ-026 With UART_RX_FIFO_EN defined, the buffer SHALL be a 4-entry FIFO with 2-bit wrapping pointers; rx_data = head entry; receive_flag = not empty.
REQ-027 Without UART_RX_FIFO_EN, the buffer SHALL be a single holding register plus a valid bit; full = valid.

Structure
REQ-028 Package uart_pkg SHALL hold the FSM state typedef, the default CLKS_PER_BIT and the FIFO depth constant (4).
REQ-029 The FIFO SHALL be sub-module uart_rx_fifo, instantiated only under UART_RX_FIFO_EN.

Verification (CLKS_PER_BIT = 16)
REQ-030 Frame 0xA5 with a valid stop bit -> receive_flag rises the cycle after the stop sample; rx_data = 0xA5; rd_ack -> receive_flag = 0.
REQ-031 rx low for 4 cycles then high -> FSM returns to IDLE; receive_flag stays 0; frame_err stays 0.
REQ-032 Frame 0x3C with stop bit = 0 -> frame_err pulses for exactly one cycle; receive_flag stays 0.
REQ-033 Without the macro: 0x11 then 0x22, no rd_ack -> rx_data = 0x11, overrun = 1; rd_ack -> overrun = 0, receive_flag = 0.
REQ-034 With the macro: 0x01..0x05, no rd_ack -> overrun = 1; four rd_acks yield 0x01..0x04 in order, then receive_flag = 0.
REQ-035 rx_en dropped in DATA at bit 3, and reset asserted in STOP -> no push, FSM in IDLE; reset case shows all outputs at reset values.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver: FSM state encoding,
// default bit period and receive FIFO depth.
package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 434;
   localparam int FIFO_DEPTH           = 4;
   localparam int FIFO_PTR_W           = $clog2(FIFO_DEPTH);
   localparam int CNT_W                = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Four-entry byte FIFO with wrapping pointers. The output holds the last
// popped byte while empty so the CPU-facing data register never goes stale.
module uart_rx_fifo
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_push,
   input  logic       i_pop,
   input  logic [7:0] i_data,
   output logic [7:0] o_data,
   output logic       o_empty,
   output logic       o_full
);

   logic [7:0]            r_mem [FIFO_DEPTH];
   logic [FIFO_PTR_W-1:0] r_wr_ptr;
   logic [FIFO_PTR_W-1:0] r_rd_ptr;
   logic [FIFO_PTR_W:0]   r_count;
   logic [7:0]            r_last;
   logic                  w_do_push;
   logic                  w_do_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (FIFO_PTR_W+1)'(FIFO_DEPTH));

   // A pop frees a slot in the same cycle, so push+pop on a full FIFO succeeds.
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_last   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_last   <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= r_count + {{FIFO_PTR_W{1'b0}}, w_do_push}
                            - {{FIFO_PTR_W{1'b0}}, w_do_pop};
      end
   end

   assign o_data = o_empty ? r_last : r_mem[r_rd_ptr];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a CPU-side receive buffer.
// Define UART_RX_FIFO_EN for a 4-entry FIFO; otherwise a single holding register.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_en,
   input  logic       rx,
   input  logic       rd_ack,
   output logic [7:0] rx_data,
   output logic       receive_flag,
   output logic       frame_err,
   output logic       overrun
);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   rx_state_t        r_state;
   rx_state_t        w_next;
   logic             r_rx_meta;
   logic             r_rx_sync;
   logic [CNT_W-1:0] r_clk_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic             r_frame_err;
   logic             r_overrun;
   logic             w_tick;
   logic             w_sample_bit;
   logic             w_push;
   logic             w_ferr;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic [7:0]       w_buf_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;
      end
   end

   // Start bit is checked at mid-bit; data and stop bits one full period apart.
   assign w_tick = (r_state == ST_START) ? (r_clk_cnt == HALF_LAST)
                                         : (r_clk_cnt == BIT_LAST);

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (!r_rx_sync && rx_en) w_next = ST_START;
         ST_START: begin
            if (!rx_en)      w_next = ST_IDLE;
            else if (w_tick) w_next = r_rx_sync ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            if (!rx_en)                           w_next = ST_IDLE;
            else if (w_tick && r_bit_idx == 3'd7) w_next = ST_STOP;
         end
         ST_STOP: begin
            if (!rx_en || w_tick) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_sample_bit = 1'b0;
      w_push       = 1'b0;
      w_ferr       = 1'b0;
      case (r_state)
         ST_DATA: w_sample_bit = rx_en & w_tick;
         ST_STOP: begin
            w_push = rx_en & w_tick &  r_rx_sync;
            w_ferr = rx_en & w_tick & ~r_rx_sync;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_clk_cnt   <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_frame_err <= 1'b0;
      end else begin
         if (r_state == ST_IDLE || w_tick || !rx_en) r_clk_cnt <= '0;
         else                                        r_clk_cnt <= r_clk_cnt + 1'b1;

         if (r_state == ST_IDLE) r_bit_idx <= '0;
         else if (w_sample_bit)  r_bit_idx <= r_bit_idx + 1'b1;

         if (w_sample_bit) r_shift <= {r_rx_sync, r_shift[7:1]};

         r_frame_err <= w_ferr;
      end
   end

   assign w_pop = rd_ack & ~w_empty;

`ifdef UART_RX_FIFO_EN
   uart_rx_fifo u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (rd_ack),
      .i_data  (r_shift),
      .o_data  (w_buf_data),
      .o_empty (w_empty),
      .o_full  (w_full)
   );
`else
   logic [7:0] r_hold;
   logic       r_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hold  <= '0;
         r_valid <= 1'b0;
      end else if (w_push && (!r_valid || w_pop)) begin
         r_hold  <= r_shift;
         r_valid <= 1'b1;
      end else if (w_pop) begin
         r_valid <= 1'b0;
      end
   end

   assign w_buf_data = r_hold;
   assign w_empty    = ~r_valid;
   assign w_full     = r_valid;
`endif

   // A simultaneous rd_ack makes room, so only an unserviced full push overruns.
   always_ff @(posedge clk) begin
      if (reset)                              r_overrun <= 1'b0;
      else if (rd_ack)                        r_overrun <= 1'b0;
      else if (w_push && w_full)              r_overrun <= 1'b1;
   end

   assign rx_data      = w_buf_data;
   assign receive_flag = ~w_empty;
   assign frame_err    = r_frame_err;
   assign overrun      = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks/bit; expected bytes go to a queue
// and a monitor compares rx_data whenever the CPU side acknowledges a byte.
module tb_uart_rx;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_en = 1'b1;
   logic       rx = 1'b1;
   logic       rd_ack = 1'b0;
   logic [7:0] rx_data;
   logic       receive_flag;
   logic       frame_err;
   logic       overrun;

   int n_pass = 0;
   int n_tot  = 0;
   int fe_cnt = 0;
   logic [7:0] exp_q [$];

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_en        (rx_en),
      .rx           (rx),
      .rd_ack       (rd_ack),
      .rx_data      (rx_data),
      .receive_flag (receive_flag),
      .frame_err    (frame_err),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Scoreboard monitor: each acknowledged byte must match the oldest expected one.
   always @(negedge clk) begin
      if (!reset && frame_err) fe_cnt++;
      if (!reset && rd_ack && receive_flag) begin
         if (exp_q.size() == 0) chk("unexpected_byte", {24'h0, rx_data}, 32'hffff_ffff);
         else                   chk("rx_data_pop", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic v);
      rx = v;
      cyc(CPB);
   endtask

   task automatic send_head(input logic [7:0] b);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
   endtask

   task automatic send(input logic [7:0] b, input logic stop_bit);
      send_head(b);
      drive_bit(stop_bit);
      rx = 1'b1;
      cyc(4);
   endtask

   task automatic ack();
      rd_ack = 1'b1;
      cyc(1);
      rd_ack = 1'b0;
      cyc(1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int fe0;
      cyc(3);
      reset = 1'b0;
      chk("rst_rx_data", {24'h0, rx_data}, 32'h0);
      chk("rst_receive_flag", {31'h0, receive_flag}, 32'h0);
      chk("rst_frame_err", {31'h0, frame_err}, 32'h0);
      chk("rst_overrun", {31'h0, overrun}, 32'h0);
      cyc(5);

      // Good frame 0xA5
      exp_q.push_back(8'hA5);
      send_head(8'hA5);
      chk("a5_flag_before_stop", {31'h0, receive_flag}, 32'h0);
      drive_bit(1'b1);
      chk("a5_flag_after_stop", {31'h0, receive_flag}, 32'h1);
      chk("a5_rx_data", {24'h0, rx_data}, 32'hA5);
      cyc(4);
      ack();
      chk("a5_flag_after_ack", {31'h0, receive_flag}, 32'h0);
      ack();
      chk("empty_ack_hold_data", {24'h0, rx_data}, 32'hA5);
      chk("empty_ack_flag", {31'h0, receive_flag}, 32'h0);

      // False start: 4 low cycles
      fe0 = fe_cnt;
      rx = 1'b0;
      cyc(4);
      rx = 1'b1;
      cyc(3 * CPB);
      chk("false_start_flag", {31'h0, receive_flag}, 32'h0);
      chk("false_start_ferr", fe_cnt - fe0, 32'h0);

      // Bad stop bit on 0x3C
      fe0 = fe_cnt;
      send(8'h3C, 1'b0);
      cyc(CPB);
      chk("ferr_pulse_cycles", fe_cnt - fe0, 32'h1);
      chk("ferr_flag", {31'h0, receive_flag}, 32'h0);

`ifdef UART_RX_FIFO_EN
      for (int i = 1; i <= 5; i++) begin
         if (i <= 4) exp_q.push_back(8'(i));
         send(8'(i), 1'b1);
      end
      chk("fifo_overrun_set", {31'h0, overrun}, 32'h1);
      chk("fifo_head", {24'h0, rx_data}, 32'h01);
      ack();
      chk("fifo_overrun_clr", {31'h0, overrun}, 32'h0);
      for (int i = 0; i < 3; i++) ack();
      chk("fifo_drained_flag", {31'h0, receive_flag}, 32'h0);
`else
      exp_q.push_back(8'h11);
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      chk("hold_rx_data", {24'h0, rx_data}, 32'h11);
      chk("hold_overrun_set", {31'h0, overrun}, 32'h1);
      ack();
      chk("hold_overrun_clr", {31'h0, overrun}, 32'h0);
      chk("hold_flag_clr", {31'h0, receive_flag}, 32'h0);
`endif

      // rx_en dropped mid-DATA (bit 3)
      fe0 = fe_cnt;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(1'b0);
      rx = 1'b0;
      cyc(CPB / 2);
      rx_en = 1'b0;
      rx = 1'b1;
      cyc(4);
      rx_en = 1'b1;
      cyc(12 * CPB);
      chk("abort_flag", {31'h0, receive_flag}, 32'h0);
      chk("abort_ferr", fe_cnt - fe0, 32'h0);

      // Reset during STOP with a byte already buffered
      send(8'h77, 1'b1);
      chk("pre_reset_flag", {31'h0, receive_flag}, 32'h1);
      send_head(8'h99);
      rx = 1'b1;
      cyc(6);
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      chk("stop_rst_rx_data", {24'h0, rx_data}, 32'h0);
      chk("stop_rst_flag", {31'h0, receive_flag}, 32'h0);
      chk("stop_rst_ferr", {31'h0, frame_err}, 32'h0);
      chk("stop_rst_overrun", {31'h0, overrun}, 32'h0);
      cyc(3 * CPB);
      chk("stop_rst_no_push", {31'h0, receive_flag}, 32'h0);

      // Recovery frame
      exp_q.push_back(8'h5A);
      send(8'h5A, 1'b1);
      chk("recover_rx_data", {24'h0, rx_data}, 32'h5A);
      ack();
      chk("queue_drained", exp_q.size(), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
